safety_monitor_top: RTL and testbench
=====================================

SAFETY_MONITOR_TOP -- requirements
Module: safety_monitor_top

Interface
REQ-001 Parameter ACCEL_THRESH, default 16'h01D9: accelerator limit; a sample strictly above it is aggressive.
REQ-002 Parameter BRAKE_THRESH, default 16'h0100: brake-applied level; a sample at or above it counts as braking.
REQ-003 Parameter STUCK_LIMIT, default 200: number of consecutive identical accel samples that declares a stuck sensor.
REQ-004 clk  input  1: single clock; all logic rising-edge.
REQ-005 rst  input  1: reset, synchronous, active-high.
REQ-006 spi_accel  input  16: unsigned accelerator sample, valid every cycle.
REQ-007 spi_brake  input  16: unsigned brake sample, valid every cycle.
REQ-008 led_status  output  3: one-hot state, with IDLE=3'b001, WARNING=3'b010 and FAILSAFE=3'b100.

Function
REQ-009 Both inputs SHALL be registered once (accel_q, brake_q); all decisions use the registered values.
REQ-010 The FSM SHALL have states IDLE, WARNING and FAILSAFE; led_status SHALL be the registered state encoding.
REQ-011 IDLE->WARNING SHALL occur when accel_q > ACCEL_THRESH, or when accel_q > ACCEL_THRESH/2 and brake_q >= BRAKE_THRESH (pedal conflict).
REQ-012 WARNING->IDLE SHALL occur when neither WARNING condition holds for 4 consecutive cycles; any recurrence restarts the 4-cycle count.
REQ-013 Any state->FAILSAFE SHALL occur when the stuck counter reaches STUCK_LIMIT.
REQ-014 FAILSAFE SHALL be latched; only rst exits it.
REQ-015 The stuck counter SHALL increment when accel_q equals the previous accel_q, saturate at STUCK_LIMIT, and clear to 0 on any change.
REQ-016 When the stuck and WARNING conditions occur in the same cycle, FAILSAFE SHALL take priority.
REQ-017 Latency from an input change at the port to led_status SHALL be exactly 2 cycles for the WARNING entry and the FAILSAFE entry.
REQ-018 accel_q == ACCEL_THRESH exactly SHALL NOT trigger WARNING.
REQ-019 Comparisons SHALL be unsigned 16-bit; no arithmetic overflow is possible.

Reset
REQ-020 While rst=1: state SHALL be IDLE, led_status SHALL be 3'b001, accel_q, brake_q and the previous-sample register SHALL be 0, and all counters SHALL be 0.
REQ-021 rst asserted mid-operation, including in FAILSAFE, SHALL force IDLE on the next rising edge.
REQ-022 After reset the stuck counter SHALL count 0x0000 as a normal value; a constant input after reset SHALL reach FAILSAFE after STUCK_LIMIT cycles.

Configuration
REQ-023 Macro STUCK_DETECT_EN: when defined, REQ-013 and REQ-015 SHALL be implemented.
REQ-024 When STUCK_DETECT_EN is undefined, the stuck counter SHALL be removed, FAILSAFE SHALL be unreachable, and the FSM SHALL toggle only between IDLE and WARNING.

Structure
REQ-025 Package safety_pkg SHALL hold the state typedef, the state encodings, and the default values of ACCEL_THRESH, BRAKE_THRESH and STUCK_LIMIT.
REQ-026 Stuck detection SHALL be a sub-module named stuck_detector, with inputs clk, rst and sample[15:0] and output stuck.

Verification
REQ-027 Reset for 10 cycles, then accel=16'h0050 and brake=0 for 20 cycles -> led_status=3'b001 throughout.
REQ-028 accel=16'h0200 for 20 cycles -> led_status=3'b010 from the 2nd cycle; then accel=16'h0050 -> 3'b001 after 4 further cycles.
REQ-029 accel=16'h01D9 (threshold exactly) -> remains 3'b001; accel=16'h01DA -> 3'b010.
REQ-030 accel=16'h0100 with brake=16'h0200 -> 3'b010.
REQ-031 accel=16'hDEAD held 300 cycles -> 3'b100 by cycle STUCK_LIMIT+2; remains 3'b100 after accel changes; rst=1 for 1 cycle -> 3'b001.
REQ-032 accel alternates 16'h0050/16'h0051 every cycle for 500 cycles -> never 3'b100.

Source files
------------

// File: rtl/safety_pkg.sv
// Shared types, state encodings and default thresholds for the pedal safety monitor.
package safety_pkg;

  localparam logic [15:0] ACCEL_THRESH_DEF = 16'h01D9;
  localparam logic [15:0] BRAKE_THRESH_DEF = 16'h0100;
  localparam int unsigned STUCK_LIMIT_DEF  = 200;

  // One-hot so the state register can drive the status LEDs directly.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'b001;
  localparam state_t ST_WARNING  = 3'b010;
  localparam state_t ST_FAILSAFE = 3'b100;

  localparam int unsigned QUIET_CYCLES = 4;

endpackage

// File: rtl/safety_monitor_if.sv
// Sensor samples in, status LEDs out; master drives sensors, slave is the monitor.
interface safety_monitor_if;

  logic [15:0] spi_accel;
  logic [15:0] spi_brake;
  logic [2:0]  led_status;

  modport master (output spi_accel, output spi_brake, input  led_status);
  modport slave  (input  spi_accel, input  spi_brake, output led_status);

endinterface

// File: rtl/stuck_detector.sv
// Flags a sensor whose sample has repeated for LIMIT consecutive cycles.
module stuck_detector
  import safety_pkg::*;
#(
  parameter int unsigned LIMIT = STUCK_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sample,
  output logic        stuck
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [15:0]   prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = '0;
    if (sample == prev_q) begin
      cnt_d = (cnt_q == LIMIT_C) ? cnt_q : cnt_q + CW'(1);
    end
  end

  // Asserted on the cycle the counter lands on LIMIT, so the FSM moves on the same edge.
  assign stuck = (cnt_d == LIMIT_C);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= sample;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/safety_monitor_top.sv
// Pedal safety monitor: IDLE/WARNING/FAILSAFE FSM on registered accel/brake samples.
// Stuck-sensor detection and the FAILSAFE state are enabled by defining STUCK_DETECT_EN.
module safety_monitor_top
  import safety_pkg::*;
#(
  parameter logic [15:0] ACCEL_THRESH = ACCEL_THRESH_DEF,
  parameter logic [15:0] BRAKE_THRESH = BRAKE_THRESH_DEF,
  parameter int unsigned STUCK_LIMIT  = STUCK_LIMIT_DEF
) (
  input logic             clk,
  input logic             rst,
  safety_monitor_if.slave bus
);

  localparam logic [15:0] ACCEL_HALF = ACCEL_THRESH >> 1;
  localparam logic [1:0]  QUIET_LAST = 2'(QUIET_CYCLES - 1);

  logic [15:0] accel_q;
  logic [15:0] brake_q;
  state_t      state_q;
  state_t      state_d;
  logic [1:0]  quiet_q;
  logic [1:0]  quiet_d;
  logic        warn;
  logic        stuck;

`ifdef STUCK_DETECT_EN
  stuck_detector #(
    .LIMIT (STUCK_LIMIT)
  ) u_stuck (
    .clk    (clk),
    .rst    (rst),
    .sample (accel_q),
    .stuck  (stuck)
  );
`else
  logic unused_stuck_limit;
  assign unused_stuck_limit = ^STUCK_LIMIT;
  assign stuck = 1'b0;
`endif

  // Pedal conflict: moderate throttle while the brake is applied.
  assign warn = (accel_q > ACCEL_THRESH) ||
                ((accel_q > ACCEL_HALF) && (brake_q >= BRAKE_THRESH));

  always_comb begin
    state_d = state_q;
    quiet_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (warn) state_d = ST_WARNING;
      end
      ST_WARNING: begin
        if (!warn) begin
          if (quiet_q == QUIET_LAST) state_d = ST_IDLE;
          else                       quiet_d = quiet_q + 2'd1;
        end
      end
      ST_FAILSAFE: state_d = ST_FAILSAFE;
      default:     state_d = ST_IDLE;
    endcase
    // Stuck sensor overrides any warning decision taken this cycle.
    if (stuck) state_d = ST_FAILSAFE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accel_q <= '0;
      brake_q <= '0;
      state_q <= ST_IDLE;
      quiet_q <= '0;
    end else begin
      accel_q <= bus.spi_accel;
      brake_q <= bus.spi_brake;
      state_q <= state_d;
      quiet_q <= quiet_d;
    end
  end

  assign bus.led_status = state_q;

endmodule

// File: tb/tb_safety_monitor_top.sv
// Scoreboard bench: stimulus pushes expected led_status per cycle, a monitor pops and compares.
module tb_safety_monitor_top;
  import safety_pkg::*;

  localparam logic [2:0] I = 3'b001;
  localparam logic [2:0] W = 3'b010;
  localparam logic [2:0] F = 3'b100;
  localparam int         L = 200;

`ifdef STUCK_DETECT_EN
  localparam logic [2:0] DEAD_TAIL   = F;
  localparam logic [2:0] AFTER_DEAD  = F;
  localparam logic [2:0] CONST_LATE  = F;
`else
  localparam logic [2:0] DEAD_TAIL   = W;
  localparam logic [2:0] AFTER_DEAD  = I;
  localparam logic [2:0] CONST_LATE  = I;
`endif

  typedef struct {
    logic [2:0] exp;
    int         seg;
    int         idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   seg_id   = 0;

  always #5 clk = ~clk;

  safety_monitor_if bus ();

  safety_monitor_top dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Drive n cycles of one input vector; cycles before index k expect pre, the rest post.
  task automatic seg(input logic r, input logic [15:0] a, input logic [15:0] b,
                     input int n, input int k, input logic [2:0] pre, input logic [2:0] post);
    seg_id++;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst           = r;
      bus.spi_accel = a;
      bus.spi_brake = b;
      sb_q.push_back('{exp: (i < k) ? pre : post, seg: seg_id, idx: i});
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (bus.led_status === e.exp) n_pass++;
        else $display("FAIL seg%0d cycle%0d led_status got %b expected %b",
                      e.seg, e.idx, bus.led_status, e.exp);
      end
    end
  end

  initial begin : stimulus
    bus.spi_accel = '0;
    bus.spi_brake = '0;
    seg(1'b1, 16'h0000, 16'h0000, 10, 0, I, I);   // reset
    seg(1'b0, 16'h0050, 16'h0000, 20, 0, I, I);   // quiet driving
    seg(1'b0, 16'h0200, 16'h0000, 20, 1, I, W);   // over threshold
    seg(1'b0, 16'h0050, 16'h0000, 10, 4, W, I);   // 4 quiet cycles to exit
    seg(1'b0, 16'h0200, 16'h0000,  2, 1, I, W);
    seg(1'b0, 16'h0050, 16'h0000,  2, 0, W, W);
    seg(1'b0, 16'h0200, 16'h0000,  1, 0, W, W);   // recurrence restarts quiet count
    seg(1'b0, 16'h0050, 16'h0000,  6, 4, W, I);
    seg(1'b0, 16'h01D9, 16'h0000, 10, 0, I, I);   // exactly threshold
    seg(1'b0, 16'h01DA, 16'h0000, 10, 1, I, W);   // one above
    seg(1'b0, 16'h0050, 16'h0000,  6, 4, W, I);
    seg(1'b0, 16'h0100, 16'h0200, 10, 1, I, W);   // pedal conflict
    seg(1'b0, 16'h0100, 16'h00FF,  6, 4, W, I);   // brake just below level
    seg(1'b0, 16'h00EC, 16'h0100,  6, 0, I, I);   // accel exactly half threshold
    seg(1'b0, 16'h00ED, 16'h0100,  4, 1, I, W);   // one above half
    seg(1'b0, 16'h0050, 16'h0000,  6, 4, W, I);
    seg(1'b0, 16'hDEAD, 16'h0000, L + 1, 1, I, W);
    seg(1'b0, 16'hDEAD, 16'h0000, 300 - (L + 1), 0, DEAD_TAIL, DEAD_TAIL);
    seg(1'b0, 16'h0050, 16'h0000, 10, 4, DEAD_TAIL, AFTER_DEAD);
    seg(1'b1, 16'h0050, 16'h0000,  1, 0, I, I);   // single-cycle reset
    seg(1'b0, 16'h0050, 16'h0000,  5, 0, I, I);
    for (int j = 0; j < 500; j++) begin
      seg(1'b0, (j % 2 == 0) ? 16'h0050 : 16'h0051, 16'h0000, 1, 0, I, I);
    end
    seg(1'b1, 16'h0000, 16'h0000,  2, 0, I, I);
    seg(1'b0, 16'h0000, 16'h0000, L + 10, L - 1, I, CONST_LATE);

    for (int t = 0; t < 10 && sb_q.size() > 0; t++) begin
      @(posedge clk);
      #2;
    end
    if (sb_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain %0d expectations left, required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
